sid_spi_regs: RTL
=================

SID_SPI_REGS -- requirements
Module: sid_spi_regs

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops synchronizing spi_sck, spi_cs_n and spi_mosi into clk; legal values are 2 and 3.
REQ-002 clk  input  1  system clock; the only clock in the block.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 spi_sck  input  1  SPI serial clock, mode 0, asynchronous to clk.
REQ-005 spi_cs_n  input  1  SPI chip select, active-low; frames the transfer.
REQ-006 spi_mosi  input  1  serial data in, MSB first.
REQ-007 spi_miso  output  1  serial data out, MSB first; readback data.
REQ-008 frequency  output  16  voice frequency register.
REQ-009 duration  output  8  voice duration register.
REQ-010 attack  output  8  voice attack register.
REQ-011 sustain  output  8  voice sustain register.
REQ-012 waveform  output  8  voice waveform register.
REQ-013 frame_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 Frame format: 16 bits; bit15=1 write, bit15=0 read; bits14:8 address; bits7:0 data.
REQ-015 Register map: 0x00 frequency[7:0] shadow, 0x01 frequency[15:8], 0x02 duration, 0x03 attack, 0x04 sustain, 0x05 waveform.
REQ-016 All SPI inputs pass through SYNC_STAGES flops; edge detection is performed on the synchronized signals only.
REQ-017 Sampling: spi_mosi is sampled on the synchronized rising edge of spi_sck; spi_miso updates on the synchronized falling edge.
REQ-018 The spi_sck frequency is at most clk/8; behaviour above that rate is undefined.
REQ-019 State machine: IDLE (cs_n high) -> SHIFT on synchronized cs_n falling edge, clearing the 5-bit bit counter.
REQ-020 SHIFT -> DONE on the 16th rising edge; register write or readback completes there.
REQ-021 DONE -> IDLE on cs_n rising; SHIFT -> IDLE on cs_n rising with fewer than 16 bits received.
REQ-022 Early abort: cs_n rising with 1-15 bits received pulses frame_err for 1 clk and writes nothing.
REQ-023 Zero-bit abort: cs_n rising with 0 bits received is not an error.
REQ-024 Extra bits: SCK edges in DONE are ignored; no second write occurs and frame_err is not asserted.
REQ-025 Write latency: the target output updates on the clk cycle after the 16th synchronized rising edge is detected.
REQ-026 A write to 0x00 updates the shadow only; the frequency output is unchanged.
REQ-027 A write to 0x01 loads frequency = {data, shadow} atomically in a single cycle.
REQ-028 Writes to addresses 0x06-0x7F are ignored without error.
REQ-029 Read: after the 8th rising edge, the addressed register value loads into the shift-out register.
REQ-030 Read: spi_miso presents readback bits 7..0 on the falling edges after bits 8..15.
REQ-031 Read of 0x00 returns the shadow; reads of unmapped addresses return 0x00.
REQ-032 spi_miso drives 0 in IDLE and during bits 15:8; there is no tri-state.
REQ-033 Outputs hold their value between writes and are never glitched by an aborted frame.

Reset
REQ-034 While rst_n is low: all registers, the shadow, the bit counter and spi_miso are 0; frame_err is 0; state is IDLE.
REQ-035 Reset during SHIFT discards the partial frame and does not pulse frame_err.
REQ-036 After rst_n rises, a frame is accepted only on a new cs_n falling edge; if cs_n is already low, the block waits for cs_n high first.

Configuration
REQ-037 Macro SID_SPI_READBACK_EN: when defined, the read path of REQ-029 to REQ-031 is implemented.
REQ-038 When SID_SPI_READBACK_EN is not defined: spi_miso is constant 0, read frames are legal with no side effects, and no shift-out logic is synthesized.

Verification
REQ-039 Write 0x8255 -> duration=0x55 one clk after the 16th synchronized edge; other outputs unchanged.
REQ-040 Write 0x8034 then 0x8112 -> frequency stays 0x0000 after the first frame, then becomes 0x1234 in one cycle.
REQ-041 Write 0x85A7, then read 0x0500 (readback enabled) -> spi_miso shifts out 1010_0111 over bits 8-15; waveform stays 0xA7.
REQ-042 Write 0x83 with only 10 bits then raise cs_n -> frame_err high exactly 1 clk; attack unchanged.
REQ-043 Write 0x84FF with 20 SCK pulses -> sustain=0xFF; no frame_err; exactly one update.
REQ-044 Assert rst_n mid-frame after 9 bits -> all outputs 0, no frame_err; the next full frame writes correctly.

Source files
------------

// File: rtl/sid_spi_regs.sv
`timescale 1ns/1ps
// SPI mode-0 slave exposing the SID voice register file, fully oversampled in clk.
// Optional readback shift-out path enabled by defining SID_SPI_READBACK_EN.
module sid_spi_regs #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] frequency,
  output logic [7:0]  duration,
  output logic [7:0]  attack,
  output logic [7:0]  sustain,
  output logic [7:0]  waveform,
  output logic        frame_err
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(15);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_q, cs_q;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise_c, cs_fall_c, cs_rise_c;
  logic [CNT_W-1:0] cnt;
  logic [14:0] shift_in;
  logic [15:0] frame_c;
  logic [DATA_W-1:0] shadow;
  logic clr_cnt_c, shift_en_c, commit_c, abort_c;

  // cs chain resets low so a select already active at reset release is not taken as a new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sck_rise_c = sck_s & ~sck_q;
  assign cs_fall_c  = ~cs_s & cs_q;
  assign cs_rise_c  = cs_s & ~cs_q;
  assign frame_c    = {shift_in, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs_fall_c) state_nx = SHIFT;
      SHIFT:   if (cs_rise_c) state_nx = IDLE;
               else if (sck_rise_c && (cnt == LAST_BIT)) state_nx = DONE;
      DONE:    if (cs_rise_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clr_cnt_c  = 1'b0;
    shift_en_c = 1'b0;
    commit_c   = 1'b0;
    abort_c    = 1'b0;
    case (state)
      IDLE:  clr_cnt_c = cs_fall_c;
      SHIFT: begin
        if (cs_rise_c) begin
          abort_c = (cnt != '0);
        end else if (sck_rise_c) begin
          shift_en_c = 1'b1;
          commit_c   = (cnt == LAST_BIT);
        end
      end
      default: ;
    endcase
  end

  // Frame capture and register file; a write lands on the edge that takes in bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shift_in  <= '0;
      shadow    <= '0;
      frequency <= '0;
      duration  <= '0;
      attack    <= '0;
      sustain   <= '0;
      waveform  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort_c;
      if (clr_cnt_c)       cnt <= '0;
      else if (shift_en_c) cnt <= cnt + CNT_W'(1);
      if (shift_en_c) shift_in <= {shift_in[13:0], mosi_s};
      if (commit_c && frame_c[15]) begin
        case (frame_c[14:8])
          7'h00:   shadow    <= frame_c[7:0];
          7'h01:   frequency <= {frame_c[7:0], shadow};
          7'h02:   duration  <= frame_c[7:0];
          7'h03:   attack    <= frame_c[7:0];
          7'h04:   sustain   <= frame_c[7:0];
          7'h05:   waveform  <= frame_c[7:0];
          default: ;
        endcase
      end
    end
  end

`ifdef SID_SPI_READBACK_EN
  logic sck_fall_c, load_out_c, shift_out_c;
  logic [6:0] rd_addr_c;
  logic [DATA_W-1:0] rdata_c, shift_out;

  assign sck_fall_c  = ~sck_s & sck_q;
  assign rd_addr_c   = {shift_in[5:0], mosi_s};
  assign load_out_c  = (state == SHIFT) && !cs_rise_c && sck_rise_c && (cnt == CNT_W'(7));
  assign shift_out_c = (state == SHIFT) && !cs_rise_c && sck_fall_c && (cnt >= CNT_W'(8));

  always_comb begin
    rdata_c = '0;
    case (rd_addr_c)
      7'h00:   rdata_c = shadow;
      7'h01:   rdata_c = frequency[15:8];
      7'h02:   rdata_c = duration;
      7'h03:   rdata_c = attack;
      7'h04:   rdata_c = sustain;
      7'h05:   rdata_c = waveform;
      default: rdata_c = '0;
    endcase
  end

  // Write frames load zeros so miso stays low for them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_out <= '0;
      spi_miso  <= 1'b0;
    end else if (state == IDLE) begin
      spi_miso  <= 1'b0;
    end else if (load_out_c) begin
      shift_out <= shift_in[6] ? '0 : rdata_c;
    end else if (shift_out_c) begin
      spi_miso  <= shift_out[DATA_W-1];
      shift_out <= {shift_out[DATA_W-2:0], 1'b0};
    end
  end
`else
  assign spi_miso = 1'b0;
`endif

endmodule
